// File: rtl/aes_sbox_lane_pipe.sv
// Elastic AES SubBytes datapath: LANES byte lanes of forward/inverse S-box
// followed by STAGES valid/ready register stages. The mode bit rides with
// each beat, so mixed encrypt/decrypt traffic can share the pipe in order.

// One byte lane: forward or inverse S-box, built from a GF(2^8) inverter
// and the two affine maps. The inverter is shared between both modes.
module aes_sbox_lane (
  input  logic       inv_i,
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (0x11B)
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // a^-1 = a^254 = a^(2+4+...+128); a=0 yields 0 with no special case
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Forward affine map, constant 0x63
  function automatic logic [7:0] aff_fwd(input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] c;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      r[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8]
           ^ b[(i + 7) % 8] ^ c[i];
    return r;
  endfunction

  // Inverse affine map, constant 0x05
  function automatic logic [7:0] aff_inv(input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] d;
    d = 8'h05;
    for (int i = 0; i < 8; i++)
      r[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8] ^ d[i];
    return r;
  endfunction

  logic [7:0] inv_in;
  logic [7:0] inv_out;

  // Forward: A(x^-1). Inverse: (A^-1(x))^-1. Mux around one inverter.
  always_comb begin
    inv_in  = inv_i ? aff_inv(byte_i) : byte_i;
    inv_out = gf_inv(inv_in);
    byte_o  = inv_i ? inv_out : aff_fwd(inv_out);
  end

endmodule

module aes_sbox_lane_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_inv,
  output logic               busy
);

  typedef logic [LANES-1:0][7:0] beat_t;

  beat_t in_lanes;
  beat_t sub_w;

  assign in_lanes = in_data;

  // S-box lanes sit in front of the first register; later stages only delay
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    aes_sbox_lane u_lane (
      .inv_i  (in_inv),
      .byte_i (in_lanes[k]),
      .byte_o (sub_w[k])
    );
  end

  // Register k holds stage k+1; register STAGES-1 drives the outputs
  logic  [STAGES-1:0] vld_q;
  logic  [STAGES-1:0] vld_d;
  logic  [STAGES-1:0] inv_q;
  beat_t [STAGES-1:0] dat_q;

  // Position 0 is the input port, positions 1..STAGES are the stages
  logic  [STAGES:0] vld_pipe;
  logic  [STAGES:0] inv_pipe;
  logic  [STAGES:0] mv;
  beat_t [STAGES:0] dat_pipe;

  assign vld_pipe = {vld_q, in_valid};
  assign inv_pipe = {inv_q, in_inv};
  assign dat_pipe = {dat_q, sub_w};

  // mv[s]: content at position s moves downstream this cycle; mv[0] is accept
  always_comb begin
    mv         = '0;
    mv[STAGES] = vld_pipe[STAGES] & out_ready;
    for (int s = STAGES - 1; s >= 0; s--)
      mv[s] = vld_pipe[s] & (~vld_pipe[s+1] | mv[s+1]);
  end

  // A stage stays full unless it drains without a refill
  always_comb begin
    vld_d = '0;
    for (int k = 0; k < STAGES; k++)
      vld_d[k] = mv[k] | (vld_q[k] & ~mv[k+1]);
  end

  // Stage registers; data/mode load only when a beat actually moves in
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      inv_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < STAGES; k++) begin
        if (mv[k]) begin
          dat_q[k] <= dat_pipe[k];
          inv_q[k] <= inv_pipe[k];
        end
      end
    end
  end

  assign in_ready  = ~vld_pipe[1] | mv[1];
  assign out_valid = vld_q[STAGES-1];
  assign out_data  = dat_q[STAGES-1];
  assign out_inv   = inv_q[STAGES-1];
  assign busy      = |vld_q;

endmodule

// File: tb/tb_aes_sbox_lane_pipe.sv
// Bench for aes_sbox_lane_pipe: scoreboard on the default instance plus
// latency probes on the LANES/STAGES corner configurations.
module tb_aes_sbox_lane_pipe;

  localparam int L = 4;
  localparam int S = 2;

  // Published AES S-box, one row of 16 bytes per entry, byte 0 at the MSB
  localparam logic [127:0] SROW [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [8*L-1:0] in_data;
  logic           in_inv;
  logic           out_valid;
  logic           out_ready;
  logic [8*L-1:0] out_data;
  logic           out_inv;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] d;
    logic        inv;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  aes_sbox_lane_pipe #(.LANES(L), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_inv   (out_inv),
    .busy      (busy)
  );

  // Corner configurations: index 0=(1,1) 1=(1,4) 2=(16,1) 3=(16,4)
  logic         p_valid;
  logic         p_inv;
  logic [127:0] p_data;
  logic [3:0]   p_in_ready;
  logic [3:0]   p_out_valid;
  logic [3:0]   p_out_inv;
  logic [3:0]   p_busy;
  logic [7:0]   p0_data;
  logic [7:0]   p1_data;
  logic [127:0] p2_data;
  logic [127:0] p3_data;

  aes_sbox_lane_pipe #(.LANES(1), .STAGES(1)) u_p0 (
    .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(p_in_ready[0]),
    .in_data(p_data[7:0]), .in_inv(p_inv), .out_valid(p_out_valid[0]),
    .out_ready(1'b1), .out_data(p0_data), .out_inv(p_out_inv[0]), .busy(p_busy[0]));
  aes_sbox_lane_pipe #(.LANES(1), .STAGES(4)) u_p1 (
    .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(p_in_ready[1]),
    .in_data(p_data[7:0]), .in_inv(p_inv), .out_valid(p_out_valid[1]),
    .out_ready(1'b1), .out_data(p1_data), .out_inv(p_out_inv[1]), .busy(p_busy[1]));
  aes_sbox_lane_pipe #(.LANES(16), .STAGES(1)) u_p2 (
    .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(p_in_ready[2]),
    .in_data(p_data), .in_inv(p_inv), .out_valid(p_out_valid[2]),
    .out_ready(1'b1), .out_data(p2_data), .out_inv(p_out_inv[2]), .busy(p_busy[2]));
  aes_sbox_lane_pipe #(.LANES(16), .STAGES(4)) u_p3 (
    .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(p_in_ready[3]),
    .in_data(p_data), .in_inv(p_inv), .out_valid(p_out_valid[3]),
    .out_ready(1'b1), .out_data(p3_data), .out_inv(p_out_inv[3]), .busy(p_busy[3]));

  function automatic logic [31:0] model(input logic [31:0] d, input logic inv);
    logic [31:0] r;
    for (int k = 0; k < L; k++)
      r[8*k +: 8] = inv ? isbox[d[8*k +: 8]] : sbox[d[8*k +: 8]];
    return r;
  endfunction

  // Scoreboard: expectation pushed on accept, popped and compared on emit
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got data=%h inv=%b with nothing outstanding", out_data, out_inv);
        end else begin
          e = sbq.pop_front();
          if (out_data !== e.d || out_inv !== e.inv) begin
            failures++;
            $display("FAIL sb_beat got data=%h inv=%b want data=%h inv=%b", out_data, out_inv, e.d, e.inv);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.d   = model(in_data, in_inv);
        e.inv = in_inv;
        sbq.push_back(e);
      end
    end
  end

  // Present one beat and hold it until accepted (bounded)
  task automatic send(input logic [31:0] d, input logic inv);
    in_data  = d;
    in_inv   = inv;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL send_timeout data=%h never accepted", d);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (sbq.size() == 0 && !busy) begin
        checks++;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL drain_timeout pending=%0d busy=%b want 0 and 0", sbq.size(), busy);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b1;
    p_valid = 1'b0; p_inv = 1'b0; p_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_inv !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got v=%b d=%h i=%b busy=%b want 0 0 0 0", out_valid, out_data, out_inv, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(32'hFF53_0100, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early got out_valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h16ED_7C63 || out_inv !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_fwd got v=%b d=%h i=%b busy=%b want 1 16ed7c63 0 1", out_valid, out_data, out_inv, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_drop got busy=%b v=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] d;
    out_ready = 1'b1;
    send(32'h16ED_7C63, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hFF53_0100 || out_inv !== 1'b1) begin
      failures++;
      $display("FAIL inv_basic got v=%b d=%h i=%b want 1 ff530100 1", out_valid, out_data, out_inv);
    end
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 64; x++) begin
        for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'(4*x + k);
        send(d, m[0]);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [11:0] hist;
    hist = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; in_data = $urandom; in_inv = c[0];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      hist[c] = out_valid;
      if (c < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_in_ready beat=%0d got %b want 1", c, in_ready);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (hist !== 12'b0011_1111_1100) begin
      failures++;
      $display("FAIL b2b_out_pattern got %b want 001111111100", hist);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] a_exp;
    a_exp = model(32'h0011_2233, 1'b0);
    out_ready = 1'b0;
    send(32'h0011_2233, 1'b0);
    send(32'h4455_6677, 1'b1);
    in_valid = 1'b1; in_data = 32'h8899_AABB; in_inv = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_in_ready cycle=%0d got %b want 0", c, in_ready);
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== a_exp || out_inv !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got v=%b d=%h i=%b want 1 %h 0", c, out_valid, out_data, out_inv, a_exp);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    send(32'hDEAD_BEEF, 1'b0);
    send(32'h0102_0304, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_inv !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset got v=%b d=%h i=%b busy=%b want 0 0 0 0", out_valid, out_data, out_inv, busy);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midreset_stale cycle=%0d got out_valid=%b want 0", c, out_valid);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_param_sweep();
    int          lat [4];
    int          exp_lat [4];
    logic [7:0]  eb;
    logic        ok;
    exp_lat = '{1, 4, 1, 4};
    for (int r = 0; r < 2; r++) begin
      p_inv  = r[0];
      p_data = r[0] ? {16{8'h63}} : '0;
      eb     = r[0] ? 8'h00 : 8'h63;
      p_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (p_in_ready !== 4'hF) begin
        failures++;
        $display("FAIL param_in_ready run=%0d got %b want 1111", r, p_in_ready);
      end
      @(posedge clk); #1;
      p_valid = 1'b0;
      lat = '{0, 0, 0, 0};
      for (int c = 1; c <= 6; c++) begin
        for (int i = 0; i < 4; i++) begin
          if (p_out_valid[i] && lat[i] == 0) begin
            lat[i] = c;
            case (i)
              0:       ok = (p0_data === eb);
              1:       ok = (p1_data === eb);
              2:       ok = (p2_data === {16{eb}});
              default: ok = (p3_data === {16{eb}});
            endcase
            checks++;
            if (!ok || p_out_inv[i] !== r[0]) begin
              failures++;
              $display("FAIL param_data cfg=%0d run=%0d got %h/%h/%h/%h inv=%b want bytes %h inv=%b",
                       i, r, p0_data, p1_data, p2_data, p3_data, p_out_inv[i], eb, r[0]);
            end
          end
        end
        @(posedge clk); #1;
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (lat[i] != exp_lat[i]) begin
          failures++;
          $display("FAIL param_latency cfg=%0d run=%0d got %0d want %0d", i, r, lat[i], exp_lat[i]);
        end
      end
      checks++;
      if (p_busy !== 4'h0) begin
        failures++;
        $display("FAIL param_busy run=%0d got %b want 0000", r, p_busy);
      end
    end
  endtask

  initial begin
    logic [127:0] row;
    for (int x = 0; x < 256; x++) begin
      row     = SROW[x / 16];
      sbox[x] = row[8*(15 - (x % 16)) +: 8];
    end
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);

    test_reset();
    test_basic();
    test_sweep();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_param_sweep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
